clk_div_prog: RTL

//  Multi-channel programmable clock divider: CHANNELS independent counters derive slow

---
 rtl/clk_div_prog.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/clk_div_prog.sv
`default_nettype none
// ============================================================================
//  Module      : clk_div_prog
//  Description : Multi-channel programmable clock divider. Each channel owns
//                a free-running counter that produces a registered divided
//                clock and a one-cycle tick on the last cycle of each period.
//                Divisors are written at run time and take effect only at a
//                period boundary, so the divided clocks never glitch.
//  Revision    : 1.0  initial release
// ============================================================================
module clk_div_prog #(
   parameter int CHANNELS    = 2,
   parameter int WIDTH       = 8,
   parameter int DEFAULT_DIV = 12,
   parameter int CH_W        = 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [CHANNELS-1:0] en,
   input  logic                sync,
   input  logic                cfg_we,
   input  logic [CH_W-1:0]     cfg_ch,
   input  logic [WIDTH-1:0]    cfg_div,
   output logic [CHANNELS-1:0] clk_out,
   output logic [CHANNELS-1:0] tick,
   output logic [CHANNELS-1:0] cfg_pending
);

   localparam logic [WIDTH-1:0] c_default_div = WIDTH'(DEFAULT_DIV);
   localparam logic [WIDTH-1:0] c_min_div     = WIDTH'(2);
   localparam logic [WIDTH-1:0] c_one         = WIDTH'(1);

   // Per-channel run state: idle channels hold their outputs low.
   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   // Divisors below 2 cannot form a period with both a high and a low phase,
   // so they are clamped to 2 before being stored anywhere.
   logic [WIDTH-1:0] w_cfg_div;
   assign w_cfg_div = (cfg_div < c_min_div) ? c_min_div : cfg_div;

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      state_t           r_state;
      logic [WIDTH-1:0] r_cnt;
      logic [WIDTH-1:0] r_act_div;
      logic [WIDTH-1:0] r_shd_div;
      logic             r_pending;
      logic             r_clk;
      logic             r_tick;

      logic             w_sel;
      logic             w_running;
      logic             w_wrap;
      logic             w_boundary;
      logic [WIDTH-1:0] w_last;
      logic [WIDTH:0]   w_high_sum;
      logic [WIDTH-1:0] w_high;
      logic [WIDTH-1:0] w_cnt_nx;

      // A write whose index does not name an existing channel never matches.
      assign w_sel      = cfg_we && (cfg_ch == CH_W'(c));
      assign w_running  = (r_state == S_RUN);
      assign w_last     = r_act_div - c_one;
      assign w_wrap     = w_running && (r_cnt == w_last);
      // Idle channels and sync restarts are safe points to swap divisors,
      // as is the final cycle of a running period.
      assign w_boundary = w_wrap || sync || !w_running;

      // High-phase length (D+1)>>1, computed one bit wider so D=2^WIDTH-1
      // does not overflow before the shift.
      assign w_high_sum = {1'b0, r_act_div} + {{WIDTH{1'b0}}, 1'b1};
      assign w_high     = w_high_sum[WIDTH:1];

      // At a wrap the next count is 0, which is high and not a tick for any
      // divisor >= 2, so the old divisor is safe for the outputs there too.
      assign w_cnt_nx   = w_wrap ? '0 : (r_cnt + c_one);

      // Divisor bookkeeping and counter/output generation for this channel.
      always_ff @(posedge clk) begin
         if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_act_div <= c_default_div;
            r_shd_div <= c_default_div;
            r_pending <= 1'b0;
            r_clk     <= 1'b0;
            r_tick    <= 1'b0;
         end else begin
            // A fresh write at a boundary supersedes any older shadow value.
            if (w_sel) begin
               if (w_boundary) begin
                  r_act_div <= w_cfg_div;
                  r_pending <= 1'b0;
               end else begin
                  r_shd_div <= w_cfg_div;
                  r_pending <= 1'b1;
               end
            end else if (r_pending && w_boundary) begin
               r_act_div <= r_shd_div;
               r_pending <= 1'b0;
            end

            // Dropping enable overrides sync and any boundary restart.
            if (!en[c]) begin
               r_state <= S_IDLE;
               r_cnt   <= '0;
               r_clk   <= 1'b0;
               r_tick  <= 1'b0;
            end else begin
               case (r_state)
                  S_IDLE: begin
                     r_state <= S_RUN;
                     r_cnt   <= '0;
                     r_clk   <= 1'b1;
                     r_tick  <= 1'b0;
                  end
                  S_RUN: begin
                     if (sync) begin
                        r_cnt  <= '0;
                        r_clk  <= 1'b1;
                        r_tick <= 1'b0;
                     end else begin
                        r_cnt  <= w_cnt_nx;
                        r_clk  <= (w_cnt_nx < w_high);
                        r_tick <= (w_cnt_nx == w_last);
                     end
                  end
                  default: begin
                     r_state <= S_IDLE;
                     r_cnt   <= '0;
                     r_clk   <= 1'b0;
                     r_tick  <= 1'b0;
                  end
               endcase
            end
         end
      end

      assign clk_out[c]     = r_clk;
      assign tick[c]        = r_tick;
      assign cfg_pending[c] = r_pending;
   end

endmodule
`default_nettype wire
